step_counter_bank: RTL and testbench

- Parametrised successor to the single 8-bit free-running incrementer: CHANNELS independent WIDTH-bit counters.
- Per-channel features: enable, direction, programmable step, wrap or saturate at a configurable modulus, synchronous load, terminal-count pulses.
- Registered single-channel readout port.
- Sits in the regression/timer fabric as the general-purpose counting primitive used by generated top levels.

---
 rtl/step_counter_pkg.sv | 57 +++++
 rtl/step_counter_lane.sv | 56 +++++
 rtl/step_counter_bank.sv | 94 +++++++++
 tb/tb_step_counter_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_counter_pkg.sv
// Shared types and next-state arithmetic for the step counter bank.
// The arithmetic is sized for the widest supported lane (WIDTH <= 32, STEP_W <= 16).
package step_counter_pkg;

    typedef enum logic { MODE_WRAP = 1'b0, MODE_SAT = 1'b1 } mode_e;
    typedef enum logic { DIR_DOWN = 1'b0, DIR_UP = 1'b1 } dir_e;

    localparam int CNT_W_MAX  = 32;
    localparam int STEP_W_MAX = 16;
    localparam int ARITH_W    = CNT_W_MAX + STEP_W_MAX + 1;

    typedef logic [ARITH_W-1:0] arith_t;

    typedef struct packed {
        logic   tc;
        arith_t value;
    } next_t;

    // Returns the counter value after one step; cur is assumed already within [0, max_val].
    function automatic next_t next_count(input arith_t cur, input arith_t step,
                                         input dir_e dir, input mode_e mode,
                                         input arith_t max_val);
        next_t  res;
        arith_t modulus;
        arith_t sum;
        arith_t rem;
        res     = '0;
        modulus = max_val + arith_t'(1);
        sum     = cur + step;
        rem     = '0;
        if (dir == DIR_UP) begin
            if (sum <= max_val) begin
                res.value = sum;
            end else if (mode == MODE_SAT) begin
                res.value = max_val;
                res.tc    = (cur != max_val);
            end else begin
                res.value = sum % modulus;
                res.tc    = 1'b1;
            end
        end else begin
            if (step <= cur) begin
                res.value = cur - step;
            end else if (mode == MODE_SAT) begin
                res.value = '0;
                res.tc    = (cur != '0);
            end else begin
                // Underflow by 'borrow' lands borrow mod (max+1) below the top of the range.
                rem       = (step - cur) % modulus;
                res.value = (rem == '0) ? '0 : (modulus - rem);
                res.tc    = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/step_counter_lane.sv
// One counter channel: registered count and terminal-count pulse.
// Load has priority over counting; a zero step holds the count.
module step_counter_lane
    import step_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int MAX_VAL = (2**WIDTH) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic              sat_mode_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              tc_o
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             nxt_tc;
    arith_t           nxt_value;

    always_comb begin
        {nxt_tc, nxt_value} = next_count(arith_t'(count_q), arith_t'(step_i),
                                         dir_e'(dir_i), mode_e'(sat_mode_i),
                                         arith_t'(MAX_VAL));
        count_d = count_q;
        tc_d    = 1'b0;
        if (load_i) begin
            count_d = (load_val_i > MAX_W) ? MAX_W : load_val_i;
        end else if (en_i && (step_i != '0)) begin
            count_d = WIDTH'(nxt_value);
            tc_d    = nxt_tc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/step_counter_bank.sv
// Bank of CHANNELS independent step counters with a load demux and a registered readout port.
// Count/tc update one edge after inputs; readout returns the pre-edge count one edge after request.
module step_counter_bank
    import step_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STEP_W   = 4,
    parameter int MAX_VAL  = (2**WIDTH) - 1,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [CHANNELS-1:0]       dir_i,
    input  logic                      sat_mode_i,
    input  logic [STEP_W-1:0]         step_i,
    input  logic                      load_i,
    input  logic [CH_W-1:0]           load_ch_i,
    input  logic [WIDTH-1:0]          load_val_i,
    input  logic                      rd_req_i,
    input  logic [CH_W-1:0]           rd_ch_i,
    output logic [CHANNELS*WIDTH-1:0] count_o,
    output logic [CHANNELS-1:0]       tc_o,
    output logic                      rd_valid_o,
    output logic [WIDTH-1:0]          rd_data_o,
    output logic                      rd_err_o
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

    logic [WIDTH-1:0] lane_cnt [CHANNELS];

    // An out-of-range load_ch matches no lane, so the load is dropped everywhere.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        step_counter_lane #(
            .WIDTH   (WIDTH),
            .STEP_W  (STEP_W),
            .MAX_VAL (MAX_VAL)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en_i       (en_i[i]),
            .dir_i      (dir_i[i]),
            .sat_mode_i (sat_mode_i),
            .step_i     (step_i),
            .load_i     (load_i && (load_ch_i == CH_W'(i))),
            .load_val_i (load_val_i),
            .count_o    (lane_cnt[i]),
            .tc_o       (tc_o[i])
        );
        assign count_o[i*WIDTH +: WIDTH] = lane_cnt[i];
    end

    logic             rd_in_range;
    logic [WIDTH-1:0] rd_sel;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    assign rd_in_range = ({1'b0, rd_ch_i} < CH_LIMIT);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch_i == CH_W'(i)) begin
                rd_sel = lane_cnt[i];
            end
        end
        rd_valid_d = rd_req_i;
        rd_err_d   = rd_req_i && !rd_in_range;
        rd_data_d  = rd_data_q;
        if (rd_req_i) begin
            rd_data_d = rd_in_range ? rd_sel : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_step_counter_bank.sv
// Three bank configurations driven from shared stimulus and compared every cycle with an integer model.
module tb_step_counter_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] en, dir;
    logic       sat_mode;
    logic [3:0] step;
    logic       load;
    logic [2:0] load_ch;
    logic [7:0] load_val;
    logic       rd_req;
    logic [2:0] rd_ch;

    logic [31:0] c0;  logic [3:0] t0;  logic rv0, re0;  logic [7:0] rd0;
    logic [39:0] c1;  logic [4:0] t1;  logic rv1, re1;  logic [7:0] rd1;
    logic [23:0] c2;  logic [2:0] t2;  logic rv2, re2;  logic [7:0] rd2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    step_counter_bank #(.WIDTH(8), .CHANNELS(4), .STEP_W(4), .MAX_VAL(255)) u0 (
        .clk(clk), .rst(rst), .en_i(en[3:0]), .dir_i(dir[3:0]), .sat_mode_i(sat_mode),
        .step_i(step), .load_i(load), .load_ch_i(load_ch[1:0]), .load_val_i(load_val),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch[1:0]), .count_o(c0), .tc_o(t0),
        .rd_valid_o(rv0), .rd_data_o(rd0), .rd_err_o(re0));

    step_counter_bank #(.WIDTH(8), .CHANNELS(5), .STEP_W(4), .MAX_VAL(9)) u1 (
        .clk(clk), .rst(rst), .en_i(en), .dir_i(dir), .sat_mode_i(sat_mode),
        .step_i(step), .load_i(load), .load_ch_i(load_ch), .load_val_i(load_val),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch), .count_o(c1), .tc_o(t1),
        .rd_valid_o(rv1), .rd_data_o(rd1), .rd_err_o(re1));

    step_counter_bank #(.WIDTH(8), .CHANNELS(3), .STEP_W(4), .MAX_VAL(200)) u2 (
        .clk(clk), .rst(rst), .en_i(en[2:0]), .dir_i(dir[2:0]), .sat_mode_i(sat_mode),
        .step_i(step), .load_i(load), .load_ch_i(load_ch[1:0]), .load_val_i(load_val),
        .rd_req_i(rd_req), .rd_ch_i(rd_ch[1:0]), .count_o(c2), .tc_o(t2),
        .rd_valid_o(rv2), .rd_data_o(rd2), .rd_err_o(re2));

    // Per-instance configuration and reference state
    int MAXV [3] = '{255, 9, 200};
    int NCH  [3] = '{4, 5, 3};
    int CHW  [3] = '{2, 3, 2};
    int  mcnt [3][5];
    bit  mtc  [3][5];
    bit  mrv  [3];
    bit  mre  [3];
    int  mrd  [3];

    function automatic logic [7:0] dut_cnt(int i, int ch);
        case (i)
            0:       return c0[ch*8 +: 8];
            1:       return c1[ch*8 +: 8];
            default: return c2[ch*8 +: 8];
        endcase
    endfunction

    function automatic logic dut_tc(int i, int ch);
        case (i)
            0:       return t0[ch];
            1:       return t1[ch];
            default: return t2[ch];
        endcase
    endfunction

    function automatic logic [9:0] dut_rd(int i);
        case (i)
            0:       return {rv0, re0, rd0};
            1:       return {rv1, re1, rd1};
            default: return {rv2, re2, rd2};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < 5; ch++) begin
                mcnt[i][ch] = 0;
                mtc[i][ch]  = 1'b0;
            end
            mrv[i] = 1'b0;
            mre[i] = 1'b0;
            mrd[i] = 0;
        end
    endtask

    // Applies one clock edge's worth of the counting rules to the model.
    task automatic model_step();
        int m, lch, rch, s, stp;
        stp = int'(step);
        for (int i = 0; i < 3; i++) begin
            m   = MAXV[i];
            lch = int'(load_ch) % (1 << CHW[i]);
            rch = int'(rd_ch) % (1 << CHW[i]);
            mrv[i] = rd_req;
            mre[i] = rd_req && (rch >= NCH[i]);
            if (rd_req) mrd[i] = (rch < NCH[i]) ? mcnt[i][rch] : 0;
            for (int ch = 0; ch < NCH[i]; ch++) begin
                mtc[i][ch] = 1'b0;
                if (load && lch == ch) begin
                    mcnt[i][ch] = (int'(load_val) > m) ? m : int'(load_val);
                end else if (en[ch] && stp != 0) begin
                    s = dir[ch] ? mcnt[i][ch] + stp : mcnt[i][ch] - stp;
                    if (s > m) begin
                        mtc[i][ch]  = sat_mode ? (mcnt[i][ch] != m) : 1'b1;
                        mcnt[i][ch] = sat_mode ? m : s % (m + 1);
                    end else if (s < 0) begin
                        mtc[i][ch]  = sat_mode ? (mcnt[i][ch] != 0) : 1'b1;
                        mcnt[i][ch] = sat_mode ? 0 : ((s % (m + 1)) + (m + 1)) % (m + 1);
                    end else begin
                        mcnt[i][ch] = s;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [9:0] r;
        for (int i = 0; i < 3; i++) begin
            for (int ch = 0; ch < NCH[i]; ch++) begin
                chk($sformatf("u%0d.count[%0d]", i, ch), dut_cnt(i, ch), mcnt[i][ch]);
                chk($sformatf("u%0d.tc[%0d]", i, ch), dut_tc(i, ch), mtc[i][ch]);
            end
            r = dut_rd(i);
            chk($sformatf("u%0d.rd_valid", i), r[9], mrv[i]);
            chk($sformatf("u%0d.rd_err", i), r[8], mre[i]);
            chk($sformatf("u%0d.rd_data", i), r[7:0], mrd[i]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int exp_b [5];
        int tc_b  [5];
        int exp_c [4];
        int tc_c  [4];
        logic [9:0] r;

        rst = 1'b1; en = '0; dir = '0; sat_mode = 1'b0; step = '0;
        load = 1'b0; load_ch = '0; load_val = '0; rd_req = 1'b0; rd_ch = '0;
        model_reset();
        cycle();
        cycle();
        chk("reset_count0", dut_cnt(0, 0), 0);
        rst = 1'b0;

        // Free-running up count on ch0, step 1, wrap
        en = 5'b00001; dir = 5'b11111; step = 4'd1;
        for (int n = 1; n <= 300; n++) begin
            cycle();
            if (n == 255) chk("a_reach_255", dut_cnt(0, 0), 255);
            if (n == 256) begin
                chk("a_wrap_0", dut_cnt(0, 0), 0);
                chk("a_wrap_tc", dut_tc(0, 0), 1);
            end
            if (n == 257) chk("a_tc_clear", dut_tc(0, 0), 0);
            if (n == 300) chk("a_ch1_idle", dut_cnt(0, 1), 0);
        end

        // MAX_VAL=9, step 3 wrap sequence
        en = '0; load = 1'b1; load_ch = 3'd0; load_val = 8'd0;
        cycle();
        load = 1'b0; en = 5'b00001; step = 4'd3;
        exp_b = '{3, 6, 9, 2, 5};
        tc_b  = '{0, 0, 0, 1, 0};
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk($sformatf("b_cnt%0d", n), dut_cnt(1, 0), exp_b[n]);
            chk($sformatf("b_tc%0d", n), dut_tc(1, 0), tc_b[n]);
        end

        // Saturating down count from 6 by 4 on ch1
        sat_mode = 1'b1; en = '0; load = 1'b1; load_ch = 3'd1; load_val = 8'd6;
        cycle();
        chk("c_load6", dut_cnt(1, 1), 6);
        load = 1'b0; en = 5'b00010; dir = 5'b11101; step = 4'd4;
        exp_c = '{2, 0, 0, 0};
        tc_c  = '{0, 1, 0, 0};
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk($sformatf("c_cnt%0d", n), dut_cnt(1, 1), exp_c[n]);
            chk($sformatf("c_tc%0d", n), dut_tc(1, 1), tc_c[n]);
        end

        // Load clamp beats enable, then wrap from MAX_VAL=200
        sat_mode = 1'b0; dir = 5'b11111; step = 4'd1;
        load = 1'b1; load_ch = 3'd2; load_val = 8'hFF; en = 5'b00100;
        cycle();
        chk("d_clamp", dut_cnt(2, 2), 200);
        chk("d_clamp_tc", dut_tc(2, 2), 0);
        load = 1'b0;
        cycle();
        chk("d_wrap", dut_cnt(2, 2), 0);
        chk("d_wrap_tc", dut_tc(2, 2), 1);

        // Readout sees the pre-edge value; out-of-range channel flags an error
        en = '0; load = 1'b1; load_ch = 3'd3; load_val = 8'd7;
        cycle();
        load = 1'b0; en = 5'b01000; rd_req = 1'b1; rd_ch = 3'd3;
        cycle();
        r = dut_rd(0);
        chk("e_rd_data", r[7:0], 7);
        chk("e_rd_valid", r[9], 1);
        chk("e_cnt8", dut_cnt(0, 3), 8);
        en = '0; rd_ch = 3'd5;
        cycle();
        r = dut_rd(1);
        chk("e_err", r[8], 1);
        chk("e_err_data", r[7:0], 0);
        rd_req = 1'b0;
        cycle();
        r = dut_rd(1);
        chk("e_idle_valid", r[9], 0);

        // Asynchronous reset between edges
        load = 1'b1; load_ch = 3'd0; load_val = 8'h42; rd_req = 1'b1; rd_ch = 3'd0;
        cycle();
        chk("f_load42", dut_cnt(0, 0), 8'h42);
        load = 1'b0; en = 5'b00001; step = 4'd1;
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        #1;
        r = dut_rd(0);
        chk("f_async_cnt", dut_cnt(0, 0), 0);
        chk("f_async_valid", r[9], 0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        cycle();
        chk("f_resume", dut_cnt(0, 0), 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en       = 5'($urandom);
            dir      = 5'($urandom);
            if ($urandom_range(0, 31) == 0) sat_mode = ~sat_mode;
            step     = 4'($urandom_range(0, 15));
            load     = ($urandom_range(0, 7) == 0);
            load_ch  = 3'($urandom);
            load_val = 8'($urandom);
            rd_req   = 1'($urandom);
            rd_ch    = 3'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
